// File: rtl/rr_arb_mux_if.sv
// Handshake bundle between N requesters and one registered output stage of
// the round-robin arbitrating mux. The slave modport is the mux's view.
interface rr_arb_mux_if #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4
);
  localparam int SELW = $clog2(NCH);

  logic [NCH-1:0]       in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_sel;
  logic                 out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_arb_mux.sv
// N-channel arbitrating multiplexer with a single registered output stage.
// A combinational arbiter (round-robin or fixed priority) picks one valid
// requester whenever the output register can take a beat; the chosen
// channel's data and index are captured on the next rising edge.
module rr_arb_mux #(
  parameter  int WIDTH = 32,
  parameter  int NCH   = 4,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic clk,
  input  logic reset,
  input  logic prio_mode,
  rr_arb_mux_if.slave bus
);

  // NCH widened by one bit so pointer+offset sums can be compared directly.
  localparam logic [SELW:0]   LP_NCH  = (SELW+1)'(NCH);
  localparam logic [SELW-1:0] LP_LAST = SELW'(NCH-1);

  logic             r_outValid;
  logic [WIDTH-1:0] r_outData;
  logic [SELW-1:0]  r_outSel;
  logic [SELW-1:0]  r_ptr;

  logic             w_load;
  logic             w_anyValid;
  logic             w_take;
  logic [SELW:0]    w_idx;
  logic             w_rrFound;
  logic [SELW-1:0]  w_rrGrant;
  logic [SELW-1:0]  w_fixGrant;
  logic [SELW-1:0]  w_grant;
  logic [SELW-1:0]  w_nextPtr;
  logic [WIDTH-1:0] w_grantData;

  // The stage accepts a new beat when empty or when its beat leaves now;
  // nothing is accepted while reset is held.
  assign w_load     = !r_outValid | bus.out_ready;
  assign w_anyValid = |bus.in_valid;
  assign w_take     = w_load & w_anyValid & !reset;
  assign w_grant    = prio_mode ? w_fixGrant : w_rrGrant;
  assign w_nextPtr  = (w_grant == LP_LAST) ? '0 : w_grant + 1'b1;

  // Round-robin search from r_ptr upward, wrapping explicitly at NCH so
  // non-power-of-two channel counts never produce an out-of-range index.
  always_comb begin
    w_rrGrant = '0;
    w_rrFound = 1'b0;
    w_idx     = '0;
    for (int k = 0; k < NCH; k++) begin
      w_idx = {1'b0, r_ptr} + (SELW+1)'(k);
      if (w_idx >= LP_NCH) begin
        w_idx = w_idx - LP_NCH;
      end
      if (!w_rrFound && bus.in_valid[w_idx[SELW-1:0]]) begin
        w_rrGrant = w_idx[SELW-1:0];
        w_rrFound = 1'b1;
      end
    end
  end

  // Fixed priority: scanning downward leaves the lowest valid index last.
  always_comb begin
    w_fixGrant = '0;
    for (int i = NCH-1; i >= 0; i--) begin
      if (bus.in_valid[i]) begin
        w_fixGrant = SELW'(i);
      end
    end
  end

  // Data select by compare-and-pick so the index never needs multiplying.
  always_comb begin
    w_grantData = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_grant == SELW'(i)) begin
        w_grantData = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Ready goes only to the granted channel and depends on valids, out_ready
  // and reset, never on the data lanes.
  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_take && (w_grant == SELW'(i))) begin
        bus.in_ready[i] = 1'b1;
      end
    end
  end

  // Output register and rotation pointer. A firing beat is replaced in the
  // same edge when a new grant is taken, so back-to-back beats see no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outSel   <= '0;
      r_ptr      <= '0;
    end else if (w_load) begin
      if (w_anyValid) begin
        r_outValid <= 1'b1;
        r_outData  <= w_grantData;
        r_outSel   <= w_grant;
        if (!prio_mode) begin
          r_ptr <= w_nextPtr;
        end
      end else begin
        r_outValid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = r_outValid;
  assign bus.out_data  = r_outData;
  assign bus.out_sel   = r_outSel;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: a 4-channel and a 3-channel instance,
// hand-computed grant sequences for each scenario.
module tb_rr_arb_mux;

  logic clk;
  logic reset;
  logic prioMode;
  logic prioMode3;
  int   total;
  int   bad;

  rr_arb_mux_if #(.WIDTH(32), .NCH(4)) bus4();
  rr_arb_mux_if #(.WIDTH(32), .NCH(3)) bus3();

  rr_arb_mux #(.WIDTH(32), .NCH(4)) dut4 (
    .clk(clk), .reset(reset), .prio_mode(prioMode), .bus(bus4)
  );

  rr_arb_mux #(.WIDTH(32), .NCH(3)) dut3 (
    .clk(clk), .reset(reset), .prio_mode(prioMode3), .bus(bus3)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic rdy, input logic prio);
    bus4.in_valid  = valid;
    bus4.out_ready = rdy;
    prioMode       = prio;
    #1;
  endtask

  task automatic checkBeat(input string tag, input logic [1:0] sel, input logic [31:0] data);
    checkOutput({tag, "_valid"}, 32'(bus4.out_valid), 32'd1);
    checkOutput({tag, "_sel"},   32'(bus4.out_sel),   32'(sel));
    checkOutput({tag, "_data"},  bus4.out_data,       data);
  endtask

  task automatic doReset();
    reset          = 1'b1;
    bus4.in_valid  = 4'hF;
    bus4.out_ready = 1'b1;
    prioMode       = 1'b0;
    bus3.in_valid  = 3'b000;
    bus3.out_ready = 1'b1;
    #1;
    checkOutput("rst_inReady0", 32'(bus4.in_ready), 32'd0);
    repeat (2) begin
      tick();
      checkOutput("rst_inReady", 32'(bus4.in_ready), 32'd0);
      checkOutput("rst_outValid", 32'(bus4.out_valid), 32'd0);
      checkOutput("rst_outSel", 32'(bus4.out_sel), 32'd0);
      checkOutput("rst_outData", bus4.out_data, 32'd0);
    end
    reset         = 1'b0;
    bus4.in_valid = 4'h0;
    #1;
  endtask

  initial begin
    logic [1:0] expSparse [4];
    logic [1:0] expFix [3];
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    prioMode  = 1'b0;
    prioMode3 = 1'b0;
    bus4.in_valid  = '0;
    bus4.out_ready = 1'b0;
    bus3.in_valid  = '0;
    bus3.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) bus4.in_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    for (int i = 0; i < 3; i++) bus3.in_data[i*32 +: 32] = 32'hB000_0000 + 32'(i);

    // Reset, then rotation 0,1,2,3,0 with all channels valid.
    doReset();
    applyStimulus(4'hF, 1'b1, 1'b0);
    checkOutput("rel_inReady", 32'(bus4.in_ready), 32'h1);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkBeat("rot", 2'(k % 4), 32'hA000_0000 + 32'(k % 4));
    end
    applyStimulus(4'h0, 1'b1, 1'b0);
    tick();
    checkOutput("drain_valid", 32'(bus4.out_valid), 32'd0);

    // Sparse requests 1001 alternate, then wrap from ptr=3 to channel 1.
    doReset();
    expSparse = '{2'd0, 2'd3, 2'd0, 2'd3};
    applyStimulus(4'h9, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkBeat("sparse", expSparse[k], 32'hA000_0000 + 32'(expSparse[k]));
    end
    applyStimulus(4'h4, 1'b1, 1'b0);
    tick();
    checkBeat("toPtr3", 2'd2, 32'hA000_0002);
    applyStimulus(4'h6, 1'b1, 1'b0);
    checkOutput("wrap_inReady", 32'(bus4.in_ready), 32'h2);
    tick();
    checkBeat("wrap1", 2'd1, 32'hA000_0001);
    tick();
    checkBeat("wrap2", 2'd2, 32'hA000_0002);

    // Backpressure: held beat stays stable, then fires with no bubble.
    doReset();
    bus4.in_data[2*32 +: 32] = 32'hDEAD_BEEF;
    applyStimulus(4'h4, 1'b1, 1'b0);
    tick();
    checkBeat("bp_first", 2'd2, 32'hDEAD_BEEF);
    applyStimulus(4'hF, 1'b0, 1'b0);
    checkOutput("bp_inReady0", 32'(bus4.in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkBeat("bp_hold", 2'd2, 32'hDEAD_BEEF);
      checkOutput("bp_inReady", 32'(bus4.in_ready), 32'd0);
    end
    applyStimulus(4'hF, 1'b1, 1'b0);
    checkOutput("bp_release_inReady", 32'(bus4.in_ready), 32'h8);
    tick();
    checkBeat("bp_next", 2'd3, 32'hA000_0003);
    tick();
    checkBeat("bp_after", 2'd0, 32'hA000_0000);
    bus4.in_data[2*32 +: 32] = 32'hA000_0002;
    applyStimulus(4'hF, 1'b0, 1'b0);
    tick();

    // Reset while a beat is held discards it; then fixed-priority mode.
    doReset();
    applyStimulus(4'hF, 1'b1, 1'b0);
    tick();
    checkBeat("fx_pre0", 2'd0, 32'hA000_0000);
    tick();
    checkBeat("fx_pre1", 2'd1, 32'hA000_0001);
    applyStimulus(4'hE, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkBeat("fixed", 2'd1, 32'hA000_0001);
    end
    applyStimulus(4'hE, 1'b1, 1'b0);
    expFix = '{2'd2, 2'd3, 2'd1};
    for (int k = 0; k < 3; k++) begin
      tick();
      checkBeat("resume", expFix[k], 32'hA000_0000 + 32'(expFix[k]));
    end

    // Three channels: rotation wraps from 2 straight back to 0.
    doReset();
    bus3.in_valid  = 3'b111;
    bus3.out_ready = 1'b1;
    #1;
    checkOutput("n3_inReady", 32'(bus3.in_ready), 32'h1);
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput("n3_valid", 32'(bus3.out_valid), 32'd1);
      checkOutput("n3_sel", 32'(bus3.out_sel), 32'(k % 3));
      checkOutput("n3_data", bus3.out_data, 32'hB000_0000 + 32'(k % 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
